// File: rtl/shift_request_fifo_amisha_pkg.sv
// Shared widths, default FIFO geometry and the request record used by the
// rotate request FIFO and its rotate stage.
package shift_request_fifo_amisha_pkg;

    localparam int DATA_W    = 8;
    localparam int AMT_W     = 3;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = 2;

    typedef struct packed {
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
    } req_t;

    function automatic req_t pack_req(input logic [DATA_W-1:0] data,
                                      input logic [AMT_W-1:0]  amt);
        req_t r;
        r.amt  = amt;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/shift_request_fifo_amisha_rotate.sv
// Combinational 8-bit rotate-right stage; amt=0 passes the byte through.
module barrel_shifter_stage_Amisha
    import shift_request_fifo_amisha_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] y
);

    logic [2*DATA_W-1:0] dbl;

    // Shifting the byte concatenated with itself yields the rotation in the low half.
    always_comb begin
        dbl = {a, a} >> amt;
        y   = dbl[DATA_W-1:0];
    end

endmodule

// File: rtl/shift_request_fifo_amisha.sv
// Request FIFO in front of the rotate stage with a registered, back-pressurable
// result; one rotation per clock under full flow.
module shift_request_fifo_amisha
    import shift_request_fifo_amisha_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = PTR_W_DEF
) (
    input  logic              clk_amisha,
    input  logic              reset_n_amisha,
    input  logic              in_valid_amisha,
    output logic              in_ready_amisha,
    input  logic [DATA_W-1:0] a_in_amisha,
    input  logic [AMT_W-1:0]  amt_in_amisha,
    output logic              out_valid_amisha,
    input  logic              out_ready_amisha,
    output logic [DATA_W-1:0] y_out_amisha,
    output logic [PTR_W:0]    count_amisha
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    req_t              mem_q [DEPTH];
    req_t              mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] y_q, y_d;

    req_t              head;
    logic [DATA_W-1:0] rot_y;
    logic              push, pop, load, not_empty;

    assign head = mem_q[rd_ptr_q];

    barrel_shifter_stage_Amisha u_rotate (
        .a   (head.data),
        .amt (head.amt),
        .y   (rot_y)
    );

    // in_ready depends only on registered occupancy, so no input-to-ready path exists.
    always_comb begin
        not_empty       = (count_q != '0);
        in_ready_amisha = (count_q != FULL_CNT);
        load            = !out_valid_q || out_ready_amisha;
        push            = in_valid_amisha && in_ready_amisha;
        pop             = not_empty && load;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;

        if (push) begin
            mem_d[wr_ptr_q] = pack_req(a_in_amisha, amt_in_amisha);
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // With an empty FIFO the output slot simply empties; y keeps its last value.
        if (load) begin
            out_valid_d = not_empty;
            if (not_empty) begin
                y_d = rot_y;
            end
        end
    end

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    // Storage contents are only meaningful behind the pointers, so they carry no reset.
    always_ff @(posedge clk_amisha) begin
        mem_q <= mem_d;
    end

    assign out_valid_amisha = out_valid_q;
    assign y_out_amisha     = y_q;
    assign count_amisha     = count_q;

endmodule

// File: tb/tb_shift_request_fifo_amisha.sv
// Directed and randomized checks of the rotate request FIFO against a queue model.
module tb_shift_request_fifo_amisha;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [2:0] amt_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;
    logic [2:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [10:0] mq [$];
    logic        m_ov;
    logic [7:0]  m_y;

    shift_request_fifo_amisha dut (
        .clk_amisha       (clk),
        .reset_n_amisha   (reset_n),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready),
        .a_in_amisha      (a_in),
        .amt_in_amisha    (amt_in),
        .out_valid_amisha (out_valid),
        .out_ready_amisha (out_ready),
        .y_out_amisha     (y_out),
        .count_amisha     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_rot(input logic [10:0] r);
        int a, s;
        a = int'(r[7:0]);
        s = int'(r[10:8]);
        return 8'(((a >> s) | (a << (8 - s))) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        m_y  = 8'h00;
    endtask

    // Called at a negedge: drive, check against model, clock once, advance model.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [2:0] amt,
                         input logic ordy, output logic acc);
        logic [10:0] r;
        in_valid  = iv;
        a_in      = a;
        amt_in    = amt;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("y_out", 32'(y_out), 32'(m_y));
        acc = iv && (mq.size() < DEPTH);
        @(posedge clk);
        if (!m_ov || ordy) begin
            if (mq.size() > 0) begin
                r    = mq.pop_front();
                m_y  = ref_rot(r);
                m_ov = 1'b1;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (acc) mq.push_back({amt, a});
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((mq.size() > 0 || m_ov) && n < 20) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
            n++;
        end
        chk("drain_bound", 32'(mq.size() > 0 || m_ov), 32'd0);
    endtask

    initial begin
        logic acc;
        int   n;

        // Reset held with in_valid asserted
        reset_n = 1'b0; in_valid = 1'b1; a_in = 8'hA5; amt_in = 3'd3; out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y_out), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);

        // Single request: result valid one edge after acceptance
        cycle(1'b1, 8'hBB, 3'd1, 1'b1, acc);
        chk("single_acc", 32'(acc), 32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_y", 32'(y_out), 32'hDD);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
        chk("single_count", 32'(count), 32'd0);

        // Back-to-back stream
        cycle(1'b1, 8'hBB, 3'd5, 1'b1, acc);
        cycle(1'b1, 8'hBB, 3'd2, 1'b1, acc);
        chk("stream_y0", 32'(y_out), 32'hDD);
        cycle(1'b1, 8'hBB, 3'd3, 1'b1, acc);
        chk("stream_y1", 32'(y_out), 32'hEE);
        cycle(1'b1, 8'hBB, 3'd4, 1'b1, acc);
        chk("stream_y2", 32'(y_out), 32'h77);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
        chk("stream_y3", 32'(y_out), 32'hBB);
        drain();

        // Back-pressure: 4 buffered plus 1 held in the output register
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 3'(i), 1'b0, acc);
        chk("bp_count_full", 32'(count), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h3C, 3'd6, 1'b0, acc);
        chk("bp_sixth_refused", 32'(acc), 32'd0);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cycle(1'b1, 8'h3C, 3'd6, 1'b1, acc);
            n++;
        end
        chk("bp_sixth_accepted", 32'(acc), 32'd1);
        drain();

        // Push and pop together at count 2, long enough to wrap pointers
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h51 * (i + 1)), 3'(i + 2), 1'b0, acc);
        chk("pp_count2", 32'(count), 32'd2);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 8'($urandom), 3'($urandom), 1'b1, acc);
            chk("pp_count_steady", 32'(count), 32'd2);
        end
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC3 + i), 3'(i + 1), 1'b0, acc);
        chk("mid_count3", 32'(count), 32'd3);
        chk("mid_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_y", 32'(y_out), 32'h00);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 8'h81, 3'd0, 1'b1, acc);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, acc);
        chk("post_rst_y", 32'(y_out), 32'h81);
        drain();

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
